store_queue: RTL
================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-002 SHALL provide parameter DATA_W, default 32, store data width.
REQ-003 SHALL provide parameter ADDR_W, default 32, address width.
REQ-004 SHALL provide parameter RSV_ID_W, default 6, ROB/reservation tag width.
REQ-005 SHALL have one clock and an asynchronous active-low reset; ports as follows.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 nrst  in  1  asynchronous active-low reset.
REQ-008 enq_valid / enq_ready  in / out  1  store allocation handshake.
REQ-009 enq_rob_id  in  RSV_ID_W  tag of the store.
REQ-010 enq_data_id  in  RSV_ID_W  tag producing store data.
REQ-011 enq_data  in  DATA_W  store data, valid when enq_data_filled=1.
REQ-012 enq_data_filled  in  1  store data already available.
REQ-013 addr_valid  in  1  computed address strobe.
REQ-014 addr_rob_id  in  RSV_ID_W  tag of store receiving the address.
REQ-015 addr  in  ADDR_W  computed store address.
REQ-016 cdb_valid  in  1  common data bus strobe.
REQ-017 cdb  in  RSV_ID_W+DATA_W  {tag, data}.
REQ-018 commit_valid / commit_invalidate  in  1  in-order commit, discard flag.
REQ-019 commit_id  in  RSV_ID_W  tag being committed.
REQ-020 flush  in  1  discard all uncommitted entries.
REQ-021 ld_valid  in  1  load lookup request.
REQ-022 ld_addr  in  ADDR_W  load address.
REQ-023 ld_hit / ld_block  out  1  forward available / load must wait.
REQ-024 ld_data  out  DATA_W  forwarded data.
REQ-025 mem_valid / mem_ready  out / in  1  memory write handshake.
REQ-026 mem_rob_id, mem_addr, mem_data  out  RSV_ID_W, ADDR_W, DATA_W  head store fields.
REQ-027 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-028 Entries SHALL form a circular queue; head/tail pointers wrap from DEPTH-1 to 0; full = count==DEPTH.
REQ-029 enq_ready SHALL be !full && !flush, registered-full only; no same-cycle pop fall-through at full.
REQ-030 On enq_valid&&enq_ready, entry[tail] SHALL load tag, data_id, data, data_ready=enq_data_filled, addr_ready=0, committed=0, discard=0.
REQ-031 A valid entry with !data_ready SHALL capture cdb data when cdb_valid and cdb tag == data_id, including the entry being enqueued in the same cycle.
REQ-032 addr_valid SHALL set address and addr_ready of the valid entry whose tag == addr_rob_id; no match is ignored.
REQ-033 commit_valid SHALL set committed on the matching entry, and discard if commit_invalidate=1.
REQ-034 mem_valid SHALL be combinational: head valid, committed, !discard, addr_ready, data_ready.
REQ-035 Head SHALL pop on mem_valid&&mem_ready, or unconditionally in one cycle when head is committed with discard, with mem_valid=0.
REQ-036 flush SHALL set tail = head + committed-entry count and clear all uncommitted entries next cycle; committed entries keep draining.
REQ-037 Lookup (combinational, ld_valid=1): any valid entry with !addr_ready SHALL raise ld_block.
REQ-038 Otherwise the youngest valid entry with address == ld_addr SHALL be selected; if none, ld_hit=0, ld_block=0.
REQ-039 Discarded entries SHALL be excluded from lookup; with ld_valid=0, ld_hit=ld_block=0 and ld_data=0.

Reset
REQ-040 nrst low SHALL asynchronously clear all entries, pointers, count=0; mem_valid=0, enq_ready=1, ld_hit=ld_block=0, all data outputs 0; reset mid-drain drops the in-flight write.

Configuration
REQ-041 Macro STORE_QUEUE_FORWARD_EN defined: selected entry with data_ready gives ld_hit=1, ld_data=its data; not data_ready gives ld_block=1.
REQ-042 Macro STORE_QUEUE_FORWARD_EN undefined: any address match gives ld_block=1, ld_hit stays 0, and forwarding logic is absent.

Verification
REQ-043 Enqueue 8 stores (DEPTH=8) -> count=8, enq_ready=0; pop one -> enq_ready=1 next cycle; tail wraps to 0.
REQ-044 Enqueue tag 3 with data_id 9, unfilled, while cdb={9,0xDEAD} same cycle -> entry data 0xDEAD, data_ready=1.
REQ-045 Stores to 0x100 (data 0x11, then 0x22), both addressed; load 0x100 -> ld_hit=1, ld_data=0x22 (FORWARD_EN) / ld_block=1 (not).
REQ-046 Commit tag 5 with invalidate=1 at head -> popped in one cycle, mem_valid never asserted.
REQ-047 Two committed plus three uncommitted entries, flush -> count=2 next cycle; both drain to memory with mem_ready held 1.
REQ-048 nrst asserted while mem_valid=1 and mem_ready=0 -> mem_valid=0 immediately; count=0.

Source files
------------

// File: rtl/store_queue.sv
// store_queue: circular store queue with CDB data capture, in-order commit,
// flush of uncommitted stores, load address lookup and head-of-queue memory write.
//
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   enq_*                          store allocation (valid/ready, tags, data)
//   addr_valid/addr_rob_id/addr    computed address for a queued store
//   cdb_valid/cdb                  common data bus {tag, data}
//   commit_valid/commit_invalidate/commit_id   in-order commit, discard flag
//   flush                          drop all uncommitted stores
//   ld_valid/ld_addr -> ld_hit/ld_block/ld_data   load lookup
//   mem_valid/mem_ready/mem_*      head store write to memory
//   count                          occupied entries
//
// Build option: define STORE_QUEUE_FORWARD_EN to forward ready store data to
// matching loads; otherwise any address match only blocks the load.
module store_queue #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RSV_ID_W = 6
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [RSV_ID_W-1:0]          enq_rob_id,
  input  logic [RSV_ID_W-1:0]          enq_data_id,
  input  logic [DATA_W-1:0]            enq_data,
  input  logic                         enq_data_filled,
  input  logic                         addr_valid,
  input  logic [RSV_ID_W-1:0]          addr_rob_id,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         cdb_valid,
  input  logic [RSV_ID_W+DATA_W-1:0]   cdb,
  input  logic                         commit_valid,
  input  logic                         commit_invalidate,
  input  logic [RSV_ID_W-1:0]          commit_id,
  input  logic                         flush,
  input  logic                         ld_valid,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit,
  output logic                         ld_block,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [RSV_ID_W-1:0]          mem_rob_id,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]    vld_q, vld_d, drdy_q, drdy_d, ardy_q, ardy_d, cmt_q, cmt_d, disc_q, disc_d;
  logic [RSV_ID_W-1:0] tag_q [DEPTH];
  logic [RSV_ID_W-1:0] tag_d [DEPTH];
  logic [RSV_ID_W-1:0] did_q [DEPTH];
  logic [RSV_ID_W-1:0] did_d [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [ADDR_W-1:0]   addr_d [DEPTH];
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d, ncmt;

  logic [RSV_ID_W-1:0] cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic                full, enq_fire, head_disc, pop, enq_cdb_hit;

  assign cdb_tag     = cdb[RSV_ID_W+DATA_W-1:DATA_W];
  assign cdb_data    = cdb[DATA_W-1:0];
  assign full        = count_q == CW'(DEPTH);
  assign enq_ready   = !full && !flush;
  assign enq_fire    = enq_valid && enq_ready;
  assign enq_cdb_hit = cdb_valid && cdb_tag == enq_data_id;
  assign mem_valid   = vld_q[head_q] && cmt_q[head_q] && !disc_q[head_q] && ardy_q[head_q] && drdy_q[head_q];
  assign head_disc   = vld_q[head_q] && cmt_q[head_q] && disc_q[head_q];
  assign pop         = (mem_valid && mem_ready) || head_disc;
  assign mem_rob_id  = tag_q[head_q];
  assign mem_addr    = addr_q[head_q];
  assign mem_data    = data_q[head_q];
  assign count       = count_q;

  // Commits are in order, so committed entries form a contiguous run from head.
  always_comb begin
    ncmt = '0;
    for (int i = 0; i < DEPTH; i++) ncmt = ncmt + CW'(vld_q[i] & cmt_q[i]);
  end

  always_comb begin
    vld_d  = vld_q;
    drdy_d = drdy_q;
    ardy_d = ardy_q;
    cmt_d  = cmt_q;
    disc_d = disc_q;
    tag_d  = tag_q;
    did_d  = did_q;
    data_d = data_q;
    addr_d = addr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !drdy_q[i] && cdb_valid && cdb_tag == did_q[i]) begin
        drdy_d[i] = 1'b1;
        data_d[i] = cdb_data;
      end
      if (vld_q[i] && addr_valid && tag_q[i] == addr_rob_id) begin
        ardy_d[i] = 1'b1;
        addr_d[i] = addr;
      end
      if (vld_q[i] && commit_valid && tag_q[i] == commit_id) begin
        cmt_d[i]  = 1'b1;
        disc_d[i] = commit_invalidate;
      end
      if (flush && vld_q[i] && !cmt_q[i]) vld_d[i] = 1'b0;
      if (pop && PW'(i) == head_q) vld_d[i] = 1'b0;
      // Enqueue never targets the popping slot: enq_ready needs !full, and an empty queue cannot pop.
      if (enq_fire && PW'(i) == tail_q) begin
        vld_d[i]  = 1'b1;
        tag_d[i]  = enq_rob_id;
        did_d[i]  = enq_data_id;
        drdy_d[i] = enq_data_filled || enq_cdb_hit;
        data_d[i] = (!enq_data_filled && enq_cdb_hit) ? cdb_data : enq_data;
        ardy_d[i] = 1'b0;
        addr_d[i] = '0;
        cmt_d[i]  = 1'b0;
        disc_d[i] = 1'b0;
      end
    end
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = flush ? head_q + PW'(ncmt) : enq_fire ? tail_q + PW'(1) : tail_q;
    count_d = flush ? ncmt - CW'(pop) : count_q + CW'(enq_fire) - CW'(pop);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q   <= '0;
      drdy_q  <= '0;
      ardy_q  <= '0;
      cmt_q   <= '0;
      disc_q  <= '0;
      tag_q   <= '{default: '0};
      did_q   <= '{default: '0};
      data_q  <= '{default: '0};
      addr_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      drdy_q  <= drdy_d;
      ardy_q  <= ardy_d;
      cmt_q   <= cmt_d;
      disc_q  <= disc_d;
      tag_q   <= tag_d;
      did_q   <= did_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last address match is the youngest store.
  logic          pend, found;
  logic [PW-1:0] idx;
`ifdef STORE_QUEUE_FORWARD_EN
  logic [PW-1:0] sel;
`endif
  always_comb begin
    pend  = 1'b0;
    found = 1'b0;
    idx   = '0;
`ifdef STORE_QUEUE_FORWARD_EN
    sel   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (vld_q[idx] && !disc_q[idx]) begin
        if (!ardy_q[idx]) pend = 1'b1;
        else if (addr_q[idx] == ld_addr) begin
          found = 1'b1;
`ifdef STORE_QUEUE_FORWARD_EN
          sel   = idx;
`endif
        end
      end
    end
  end

`ifdef STORE_QUEUE_FORWARD_EN
  assign ld_hit   = ld_valid && !pend && found && drdy_q[sel];
  assign ld_block = ld_valid && (pend || (found && !drdy_q[sel]));
  assign ld_data  = ld_hit ? data_q[sel] : '0;
`else
  assign ld_hit   = 1'b0;
  assign ld_block = ld_valid && (pend || found);
  assign ld_data  = '0;
`endif
endmodule
